// File: rtl/fifo_level_tracker.sv
// FIFO pointer/occupancy tracker: wrap-bit pointers, registered level and flags, sticky ovf/udf.
// Optional macro LEVEL_TRISTATE_EN: level is driven only while select=1, high-Z otherwise.
module fifo_level_tracker #(
    parameter int unsigned AW    = 4,
    parameter int unsigned AF_TH = 14,
    parameter int unsigned AE_TH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic        clr_err,
    input  logic        select,
    output logic [AW:0] wptr,
    output logic [AW:0] rptr,
    output logic [AW:0] level,
    output logic        full,
    output logic        empty,
    output logic        almost_full,
    output logic        almost_empty,
    output logic        ovf,
    output logic        udf
);

    localparam int unsigned PW    = AW + 1;
    localparam int unsigned DEPTH = 1 << AW;

    logic [AW:0] wptr_q, wptr_d;
    logic [AW:0] rptr_q, rptr_d;
    logic [AW:0] level_q, level_d;
    logic        full_q, full_d;
    logic        empty_q, empty_d;
    logic        almost_full_q, almost_full_d;
    logic        almost_empty_q, almost_empty_d;
    logic        ovf_q, ovf_d;
    logic        udf_q, udf_d;
    logic        wr_acc, rd_acc;
    logic        ovf_set, udf_set;

    // Next-state: accept requests against the current flags, then derive level and flags
    // from the new pointers so everything updates on the same edge.
    always_comb begin
        wr_acc         = wr_en & ~full_q;
        rd_acc         = rd_en & ~empty_q;
        ovf_set        = wr_en & full_q & (~rd_en | empty_q);
        udf_set        = rd_en & empty_q;

        wptr_d         = wptr_q + PW'(wr_acc);
        rptr_d         = rptr_q + PW'(rd_acc);
        level_d        = wptr_d + ~rptr_d + PW'(1);

        full_d         = (level_d == PW'(DEPTH));
        empty_d        = (level_d == PW'(0));
        almost_full_d  = (level_d >= PW'(AF_TH));
        almost_empty_d = (level_d <= PW'(AE_TH));

        // Sticky errors: a set in the same cycle as clr_err wins.
        ovf_d          = ovf_set ? 1'b1 : (clr_err ? 1'b0 : ovf_q);
        udf_d          = udf_set ? 1'b1 : (clr_err ? 1'b0 : udf_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q         <= '0;
            rptr_q         <= '0;
            level_q        <= '0;
            full_q         <= 1'b0;
            empty_q        <= 1'b1;
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
            ovf_q          <= 1'b0;
            udf_q          <= 1'b0;
        end else begin
            wptr_q         <= wptr_d;
            rptr_q         <= rptr_d;
            level_q        <= level_d;
            full_q         <= full_d;
            empty_q        <= empty_d;
            almost_full_q  <= almost_full_d;
            almost_empty_q <= almost_empty_d;
            ovf_q          <= ovf_d;
            udf_q          <= udf_d;
        end
    end

    assign wptr         = wptr_q;
    assign rptr         = rptr_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = almost_full_q;
    assign almost_empty = almost_empty_q;
    assign ovf          = ovf_q;
    assign udf          = udf_q;

`ifdef LEVEL_TRISTATE_EN
    assign level = select ? level_q : {PW{1'bz}};
`else
    logic unused_select;
    assign unused_select = select;
    assign level         = level_q;
`endif

endmodule
